// File: rtl/serial_subtractor.sv
// Bit-serial 8-bit subtractor: d = a - b - bin, one bit per clock, LSB first.
// Reports borrow-out, signed overflow and zero together with a one-cycle done pulse.
module serial_subtractor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] d,
    output logic       bout,
    output logic       ovf,
    output logic       zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] a_q, b_q;
    logic       br;
    logic [2:0] idx;
    logic [6:0] d_sh;

    logic       a_i, b_i, d_bit, br_nxt, last_bit;
    logic [7:0] d_full;

    // Current bit slice of the subtraction; d_sh holds bits already produced.
    always_comb begin
        a_i      = a_q[idx];
        b_i      = b_q[idx];
        d_bit    = a_i ^ b_i ^ br;
        br_nxt   = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        last_bit = (idx == 3'd7);
        d_full   = {d_bit, d_sh};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            br   <= 1'b0;
            idx  <= '0;
            d_sh <= '0;
            d    <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q  <= a;
                        b_q  <= b;
                        br   <= bin;
                        idx  <= '0;
                        d_sh <= '0;
                    end
                end
                SHIFT: begin
                    d_sh <= {d_bit, d_sh[6:1]};
                    br   <= br_nxt;
                    idx  <= idx + 3'd1;
                    // Visible results change only here, all four together.
                    if (last_bit) begin
                        d    <= d_full;
                        bout <= br_nxt;
                        ovf  <= (a_q[7] != b_q[7]) & (d_bit != a_q[7]);
                        zero <= (d_full == 8'h00);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: table of operand/result vectors plus
// hand-written sequences for start-during-SHIFT, mid-operation reset and back-to-back starts.
`timescale 1ns/1ps
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n, start, bin;
    logic [7:0] a, b;
    logic       busy, done, bout, ovf, zero;
    logic [7:0] d;

    int checks = 0;
    int errors = 0;

    serial_subtractor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
        logic       zero;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accept one operation, then follow it to done; latency is counted in edges
    // starting with the acceptance edge itself.
    task automatic run_op(input vec_t v);
        int         edges;
        int         unstable;
        logic [10:0] held;
        @(negedge clk);
        a = v.a; b = v.b; bin = v.bin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        check("busy_after_accept", busy, 1);
        held     = {d, bout, ovf, zero};
        edges    = 1;
        unstable = 0;
        while (!done && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (!done && {d, bout, ovf, zero} !== held) unstable++;
        end
        check("outputs_stable_in_shift", unstable, 0);
        check("latency_edges", edges, 9);
        check("d", d, v.d);
        check("flags_bout_ovf_zero", {bout, ovf, zero}, {v.bout, v.ovf, v.zero});
        @(posedge clk);
        #1;
        check("done_single_then_idle", {done, busy}, 2'b00);
    endtask

    initial begin
        int n;
        int pulses;
        logic [10:0] held;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #1;
        check("reset_outputs", {busy, done, d, bout, ovf, zero}, 13'h0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Start pulse during SHIFT is ignored and not queued.
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        held = {d, bout, ovf, zero};
        pulses = 0;
        n = 1;
        repeat (3) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        n++;
        start = 1'b0;
        while (!done && n < 20) begin
            if ({d, bout, ovf, zero} !== held) pulses = 100;
            @(posedge clk);
            #1;
            n++;
        end
        check("ignored_start_stable", pulses, 0);
        check("ignored_start_latency", n, 9);
        check("ignored_start_d", d, 8'h0F);
        check("ignored_start_flags", {bout, ovf, zero}, 3'b000);
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("no_queued_request", pulses, 0);
        check("idle_after_ignored", busy, 0);

        // Reset in the 4th SHIFT cycle aborts with everything cleared at once.
        @(negedge clk);
        a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {busy, done, d, bout, ovf, zero}, 13'h0);
        pulses = 0;
        repeat (2) begin @(posedge clk); #1; if (done) pulses++; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; if (done) pulses++; end
        check("no_done_after_abort", pulses, 0);
        check("outputs_zero_after_abort", {d, bout, ovf, zero}, 11'h0);
        run_op('{8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0});

        // Start accepted on the very first edge after reset release.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'h09; b = 8'h04; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_first_edge_after_reset", busy, 1);
        n = 1;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        check("first_edge_latency", n, 9);
        check("first_edge_d", d, 8'h04);

        // Start held high: one acceptance every 10 cycles.
        @(negedge clk);
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        n = 0;
        while (!done && n < 30) begin @(posedge clk); #1; n++; end
        check("held_start_first_done", done, 1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!done && n < 30);
        check("held_start_period", n, 10);
        check("held_start_d", d, 8'h02);
        start = 1'b0;
        n = 0;
        while (busy && n < 30) begin @(posedge clk); #1; n++; end
        check("held_start_returns_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 8 bits.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a  input  8  minuend, captured when start is accepted.
REQ-006 b  input  8  subtrahend, captured when start is accepted.
REQ-007 bin  input  1  borrow-in, captured when start is accepted.
REQ-008 busy  output  1  high from the edge after acceptance until return to IDLE.
REQ-009 done  output  1  single-cycle pulse marking valid results.
REQ-010 d  output  8  difference a - b - bin, modulo 256.
REQ-011 bout  output  1  borrow-out; 1 when the unsigned result is negative.
REQ-012 ovf  output  1  two's-complement signed overflow.
REQ-013 zero  output  1  1 when d == 0x00.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 IDLE with start=1 at an edge SHALL capture a, b and bin, clear bit index to 0, and enter SHIFT.
REQ-016 SHIFT SHALL process one bit per cycle, LSB first: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); br initialised to bin.
REQ-017 SHIFT SHALL last exactly 8 edges (bits 0..7), then enter DONE.
REQ-018 On the SHIFT->DONE edge, d, bout (final br), ovf and zero SHALL be loaded together.
REQ-019 ovf SHALL equal (a7 != b7) & (d7 != a7), using the captured operands.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 Latency: start accepted at edge k -> done high in the cycle after edge k+8 -> IDLE after edge k+9.
REQ-022 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-023 start in SHIFT or DONE SHALL be ignored; captured operands SHALL not change; no request SHALL be queued.
REQ-024 a, b and bin SHALL be don't-care outside the acceptance edge.
REQ-025 d, bout, ovf and zero SHALL hold their last values until the next SHIFT->DONE edge; they SHALL not change during SHIFT.
REQ-026 With start held high continuously, operations SHALL be accepted every 10 cycles.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, with busy, done, d, bout, ovf and zero all 0, and clear the internal shift and borrow registers.
REQ-028 Reset during SHIFT or DONE SHALL abort the operation with no done pulse and no output update.
REQ-029 The first edge after rst_n rises SHALL be able to accept start.

Verification
REQ-030 a=0x05, b=0x03, bin=0 -> d=0x02, bout=0, ovf=0, zero=0; done exactly 9 edges after acceptance.
REQ-031 a=0x03, b=0x05, bin=0 -> d=0xFE, bout=1, ovf=0, zero=0.
REQ-032 a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0, ovf=1, zero=0.
REQ-033 a=0x00, b=0xFF, bin=1 -> d=0x00, bout=1, ovf=0, zero=1.
REQ-034 Start 0x10-0x01, then pulse start with a=0xFF, b=0x00 during SHIFT -> d=0x0F, exactly one done pulse; outputs stay stable throughout SHIFT.
REQ-035 Assert rst_n=0 at the 4th SHIFT cycle -> all outputs 0 at once, no done pulse; a following 0x20-0x10 operation -> d=0x10, bout=0.
